// File: rtl/ram_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ram_ctrl_pkg
// Shared constants for the RAM request/response front end and the RAM itself:
// default address/data widths, FSM state encoding and the RAM rw pin levels.
// ----------------------------------------------------------------------------
package ram_ctrl_pkg;

    // Geometry shared with the 256 x 32 RAM
    localparam int RAM_ADDR_W = 8;
    localparam int RAM_DATA_W = 32;

    // Controller FSM encoding (3-bit, legacy-compatible constants)
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WR       = 3'd1;
    localparam logic [2:0] ST_RD_ISSUE = 3'd2;
    localparam logic [2:0] ST_RD_WAIT  = 3'd3;
    localparam logic [2:0] ST_RD_HOLD  = 3'd4;

    // RAM rw pin levels
    localparam logic RAM_RW_WRITE = 1'b1;
    localparam logic RAM_RW_READ  = 1'b0;

endpackage

// File: rtl/ram_ctrl_beat_cnt.sv
// ----------------------------------------------------------------------------
// ram_ctrl_beat_cnt
// Burst bookkeeping: word address that auto-increments (wrapping modulo 2^ADDR_W)
// on each completed beat, and a beat down-counter with a last-beat flag.
//
// Ports:
//   i_clk, i_rst  clock, asynchronous active-high reset
//   i_load        latch i_addr / i_len at command acceptance
//   i_addr        start word address
//   i_len         beats minus one
//   i_step        one beat completed this cycle
//   o_addr        current beat address (registered)
//   o_last        current beat is the final one of the burst
// ----------------------------------------------------------------------------
module ram_ctrl_beat_cnt #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [LEN_W-1:0]  i_len,
    input  logic              i_step,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last
);

    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_cnt;

    // Address and remaining-beat registers; address wrap is the natural overflow
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_addr <= {ADDR_W{1'b0}};
            r_cnt  <= {LEN_W{1'b0}};
        end else if (i_load) begin
            r_addr <= i_addr;
            r_cnt  <= i_len;
        end else if (i_step) begin
            r_addr <= r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
            // The last beat leaves the counter at zero rather than underflowing
            if (r_cnt != {LEN_W{1'b0}}) begin
                r_cnt <= r_cnt - {{(LEN_W-1){1'b0}}, 1'b1};
            end else begin
                r_cnt <= r_cnt;
            end
        end else begin
            r_addr <= r_addr;
            r_cnt  <= r_cnt;
        end
    end

    assign o_addr = r_addr;
    assign o_last = (r_cnt == {LEN_W{1'b0}});

endmodule

// File: rtl/ram_ctrl.sv
// ----------------------------------------------------------------------------
// ram_ctrl
// Request/response front end for the 256 x 32 RAM. Accepts one 1-4 beat read
// or write burst at a time, sequences the RAM pins with address auto-increment
// and wrap, and returns read beats with back-pressure.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid/req_ready       command handshake (req_write, req_addr, req_len)
//   wr_valid/wr_ready/wr_data write-data beat handshake
//   rd_valid/rd_ready/rd_data read-data beat handshake
//   busy                      high whenever a command is in progress
//   ram_din/ram_address/ram_rw/ram_dout  RAM pins
// ----------------------------------------------------------------------------
module ram_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W,
    parameter int RD_LAT = 1,
    parameter int LEN_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic [DATA_W-1:0] ram_din,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_rw,
    input  logic [DATA_W-1:0] ram_dout
);

    // Latency counter width covers RD_LAT up to 3
    localparam int              LAT_W    = 2;
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RD_LAT - 1);

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [LAT_W-1:0]  r_lat;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;

    logic              w_load;
    logic              w_wr_beat;
    logic              w_rd_beat;
    logic              w_rd_capture;
    logic              w_last;
    logic [ADDR_W-1:0] w_addr;

    assign w_load       = (r_state == ST_IDLE) && req_valid;
    assign w_wr_beat    = (r_state == ST_WR) && wr_valid;
    assign w_rd_beat    = (r_state == ST_RD_HOLD) && rd_ready;
    assign w_rd_capture = (r_state == ST_RD_WAIT) && (r_lat == {LAT_W{1'b0}});

    ram_ctrl_beat_cnt #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_beat_cnt (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_load (w_load),
        .i_addr (req_addr),
        .i_len  (req_len),
        .i_step (w_wr_beat || w_rd_beat),
        .o_addr (w_addr),
        .o_last (w_last)
    );

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_state_nxt = req_write ? ST_WR : ST_RD_ISSUE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WR: begin
                if (wr_valid && w_last) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_WR;
                end
            end
            ST_RD_ISSUE: begin
                w_state_nxt = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (r_lat == {LAT_W{1'b0}}) begin
                    w_state_nxt = ST_RD_HOLD;
                end else begin
                    w_state_nxt = ST_RD_WAIT;
                end
            end
            ST_RD_HOLD: begin
                if (rd_ready) begin
                    w_state_nxt = w_last ? ST_IDLE : ST_RD_ISSUE;
                end else begin
                    w_state_nxt = ST_RD_HOLD;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register; reset drops straight to IDLE which also kills ram_rw
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Read latency counter: loaded at issue, counts down while waiting on the RAM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lat <= {LAT_W{1'b0}};
        end else begin
            case (r_state)
                ST_RD_ISSUE: r_lat <= LAT_INIT;
                ST_RD_WAIT: begin
                    if (r_lat != {LAT_W{1'b0}}) begin
                        r_lat <= r_lat - {{(LAT_W-1){1'b0}}, 1'b1};
                    end else begin
                        r_lat <= r_lat;
                    end
                end
                default: r_lat <= r_lat;
            endcase
        end
    end

    // Read beat holding register: captured once, held until the consumer takes it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= {DATA_W{1'b0}};
        end else if (w_rd_capture) begin
            r_rd_valid <= 1'b1;
            r_rd_data  <= ram_dout;
        end else if (w_rd_beat) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= r_rd_data;
        end else begin
            r_rd_valid <= r_rd_valid;
            r_rd_data  <= r_rd_data;
        end
    end

    assign req_ready   = (r_state == ST_IDLE);
    assign busy        = (r_state != ST_IDLE);
    assign wr_ready    = (r_state == ST_WR);
    // Write strobe passes through only in WR, so no other state can write the RAM
    assign ram_rw      = w_wr_beat ? RAM_RW_WRITE : RAM_RW_READ;
    assign ram_din     = (r_state == ST_WR) ? wr_data : {DATA_W{1'b0}};
    // Address always comes from the burst register, never from req_addr directly
    assign ram_address = w_addr;
    assign rd_valid    = r_rd_valid;
    assign rd_data     = r_rd_data;

endmodule

// File: tb/tb_ram_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ram_ctrl
// Bench for ram_ctrl with a behavioural RAM attached to its pins and a
// word-array reference model of the expected RAM contents.
// ----------------------------------------------------------------------------
module tb_ram_ctrl;

    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 32;
    localparam int RD_LAT   = 1;
    localparam int LEN_W    = 2;
    localparam int MAX_WAIT = 20;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic [DATA_W-1:0] ram_din;
    logic [ADDR_W-1:0] ram_address;
    logic              ram_rw;
    logic [DATA_W-1:0] ram_dout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT),
        .LEN_W  (LEN_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_data     (wr_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .busy        (busy),
        .ram_din     (ram_din),
        .ram_address (ram_address),
        .ram_rw      (ram_rw),
        .ram_dout    (ram_dout)
    );

    function automatic logic [31:0] seed_word(input int i);
        return 32'hC0DE_0000 + 32'(i) * 32'h0000_0101;
    endfunction

    // Behavioural 256 x 32 RAM with RD_LAT-cycle read pipeline, preloaded by fill_en
    logic [DATA_W-1:0] tb_mem [0:255];
    logic [DATA_W-1:0] ref_mem [0:255];
    logic [DATA_W-1:0] rd_pipe [0:RD_LAT-1];
    logic              fill_en;
    logic [7:0]        fill_ptr = 8'd0;
    int                wr_cnt = 0;

    assign ram_dout = rd_pipe[RD_LAT-1];

    always @(posedge clk) begin
        if (fill_en) begin
            tb_mem[fill_ptr] <= seed_word(int'(fill_ptr));
            fill_ptr <= fill_ptr + 8'd1;
        end else if (ram_rw) begin
            tb_mem[ram_address] <= ram_din;
            wr_cnt <= wr_cnt + 1;
        end
        rd_pipe[0] <= tb_mem[ram_address];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a command and wait (bounded) until it is accepted; ends on the negedge after acceptance
    task automatic issue_req(input logic wr, input logic [7:0] a, input logic [1:0] l, output bit ok);
        int w;
        w = 0;
        req_valid = 1'b1; req_write = wr; req_addr = a; req_len = l;
        while (!req_ready && w < MAX_WAIT) begin
            @(negedge clk);
            w++;
        end
        ok = (req_ready === 1'b1);
        if (!ok) check("req_accept_timeout", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [1:0] l, input logic [127:0] dat,
                            input int gap_beat, input int gap_len);
        logic [7:0] exp_addr;
        int         start_cnt;
        bit         ok;
        exp_addr = a;
        issue_req(1'b1, a, l, ok);
        if (!ok) return;
        start_cnt = wr_cnt;
        for (int i = 0; i <= int'(l); i++) begin
            if (i == gap_beat) begin
                for (int g = 0; g < gap_len; g++) begin
                    wr_valid = 1'b0;
                    #1;
                    check("gap_rw", 32'(ram_rw), 32'd0);
                    check("gap_addr", 32'(ram_address), 32'(exp_addr));
                    check("gap_wr_ready", 32'(wr_ready), 32'd1);
                    @(negedge clk);
                end
            end
            wr_valid = 1'b1;
            wr_data  = dat[i*32 +: 32];
            #1;
            check("wr_ready", 32'(wr_ready), 32'd1);
            check("wr_rw", 32'(ram_rw), 32'd1);
            check("wr_addr", 32'(ram_address), 32'(exp_addr));
            check("wr_din", ram_din, dat[i*32 +: 32]);
            ref_mem[exp_addr] = dat[i*32 +: 32];
            exp_addr = exp_addr + 8'd1;
            @(negedge clk);
        end
        wr_valid = 1'b0;
        #1;
        check("wr_done_busy", 32'(busy), 32'd0);
        check("wr_count", 32'(wr_cnt - start_cnt), 32'(int'(l) + 1));
    endtask

    task automatic do_read(input logic [7:0] a, input logic [1:0] l, input int stall_beat,
                           input int stall_len, input bit hold_next);
        logic [7:0]  exp_addr;
        logic [31:0] held;
        int          cyc;
        bit          rw_seen;
        bit          ok;
        exp_addr = a;
        issue_req(1'b0, a, l, ok);
        if (!ok) return;
        if (hold_next) begin
            req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_len = l;
        end
        for (int i = 0; i <= int'(l); i++) begin
            cyc = 0;
            rw_seen = 1'b0;
            while (rd_valid !== 1'b1 && cyc < MAX_WAIT) begin
                if (ram_rw !== 1'b0) rw_seen = 1'b1;
                if (hold_next) check("busy_req_ready", 32'(req_ready), 32'd0);
                @(negedge clk);
                cyc++;
            end
            check("rd_latency", 32'(cyc), 32'(RD_LAT + 1));
            check("rd_no_write", 32'(rw_seen), 32'd0);
            check("rd_data", rd_data, ref_mem[exp_addr]);
            if (hold_next) check("busy_req_ready_hold", 32'(req_ready), 32'd0);
            if (i == stall_beat) begin
                held = rd_data;
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    check("stall_valid", 32'(rd_valid), 32'd1);
                    check("stall_data", rd_data, held);
                    check("stall_addr", 32'(ram_address), 32'(exp_addr));
                end
            end
            rd_ready = 1'b1;
            @(negedge clk);
            rd_ready = 1'b0;
            exp_addr = exp_addr + 8'd1;
        end
        check("rd_done_ready", 32'(req_ready), 32'd1);
        check("rd_done_valid", 32'(rd_valid), 32'd0);
    endtask

    initial begin
        logic [7:0] ra;
        logic [1:0] rl;
        int         mism;
        bit         ok;

        rst = 1'b0; fill_en = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 8'd0; req_len = 2'd0;
        wr_valid = 1'b0; wr_data = 32'd0; rd_ready = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = seed_word(i);

        // Asynchronous reset asserted mid-cycle, before any clock edge
        #2 rst = 1'b1;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ram_rw", 32'(ram_rw), 32'd0);
        check("rst_ram_address", 32'(ram_address), 32'd0);
        check("rst_ram_din", ram_din, 32'd0);

        repeat (256) @(posedge clk);
        @(negedge clk);
        fill_en = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("idle_req_ready", 32'(req_ready), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);

        // Single write then read back
        do_write(8'h10, 2'd0, {96'd0, 32'hDEAD_BEEF}, -1, 0);
        do_read(8'h10, 2'd0, -1, 0, 1'b0);

        // Wrapping burst: 0xFE, 0xFF, 0x00, 0x01
        do_write(8'hFE, 2'd3, {32'h4, 32'h3, 32'h2, 32'h1}, -1, 0);
        do_read(8'hFE, 2'd3, -1, 0, 1'b0);

        // Write gap mid-burst, then read stall
        do_write(8'h40, 2'd3, {$urandom, $urandom, $urandom, $urandom}, 2, 3);
        do_read(8'h40, 2'd3, 1, 5, 1'b0);

        // Command held during a read burst, accepted once the burst drains
        do_read(8'h10, 2'd1, -1, 0, 1'b1);
        do_read(8'h10, 2'd1, -1, 0, 1'b0);

        // Reset during beat 2 of a 4-beat write at 0x80
        issue_req(1'b1, 8'h80, 2'd3, ok);
        wr_valid = 1'b1; wr_data = $urandom;
        #1;
        check("abort_beat1_rw", 32'(ram_rw), 32'd1);
        ref_mem[8'h80] = wr_data;
        @(negedge clk);
        wr_data = 32'hBAD0_0002;
        #2 rst = 1'b1;
        #1;
        check("abort_ram_rw", 32'(ram_rw), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_req_ready", 32'(req_ready), 32'd1);
        check("abort_wr_ready", 32'(wr_ready), 32'd0);
        check("abort_ram_address", 32'(ram_address), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        wr_valid = 1'b0;
        @(negedge clk);
        check("abort_idle", 32'(busy), 32'd0);
        check("abort_mem80", tb_mem[8'h80], ref_mem[8'h80]);
        check("abort_mem81", tb_mem[8'h81], ref_mem[8'h81]);
        check("abort_mem82", tb_mem[8'h82], ref_mem[8'h82]);
        check("abort_mem83", tb_mem[8'h83], ref_mem[8'h83]);
        do_read(8'h80, 2'd3, -1, 0, 1'b0);

        // Randomized mix of bursts against the reference array
        for (int t = 0; t < 40; t++) begin
            ra = 8'($urandom);
            rl = 2'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                do_write(ra, rl, {$urandom, $urandom, $urandom, $urandom},
                         ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, int'(rl))) : -1,
                         int'($urandom_range(1, 3)));
            end else begin
                do_read(ra, rl,
                        ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, int'(rl))) : -1,
                        int'($urandom_range(1, 4)), 1'b0);
            end
        end

        mism = 0;
        for (int i = 0; i < 256; i++) begin
            if (tb_mem[i] !== ref_mem[i]) mism++;
        end
        check("mem_final_mismatches", 32'(mism), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_ctrl.md
Name: ram_ctrl

Overview:
- Request/response front end for the 256 x 32 word RAM; sits directly upstream and drives its Din, address and rw pins.
- Accepts single or burst (1-4 beat) read/write commands from the datapath over valid/ready handshakes.
- Sequences RAM accesses, with address auto-increment and wrap, and returns read data with back-pressure support.

Parameters:
- ADDR_W, 8, RAM word-address width.
- DATA_W, 32, data word width.
- RD_LAT, 1, cycles from read address presented to ram_dout valid (range 1-3).
- LEN_W, 2, burst length field width; beats = req_len+1 (max 4).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  command valid
- req_ready  out  1  command accepted when valid&ready
- req_write  in  1  1 = write burst, 0 = read burst
- req_addr  in  ADDR_W  start word address
- req_len  in  LEN_W  beats minus one
- wr_valid  in  1  write-data beat valid
- wr_ready  out  1  write-data beat accepted
- wr_data  in  DATA_W  write-data beat
- rd_valid  out  1  read-data beat valid
- rd_ready  in  1  consumer accepts read beat
- rd_data  out  DATA_W  read-data beat
- busy  out  1  high whenever state != IDLE
- ram_din  out  DATA_W  to RAM Din
- ram_address  out  ADDR_W  to RAM address
- ram_rw  out  1  to RAM rw; 1 = write, 0 = read
- ram_dout  in  DATA_W  from RAM Dout

Behaviour:
- Clock is clk. Reset is rst, asynchronous and active-high.
- Reset values: state IDLE; req_ready=1; wr_ready=0; rd_valid=0; rd_data=0; busy=0; ram_rw=0; ram_address=0; ram_din=0; beat counter=0; latency counter=0.
- FSM states: IDLE, WR, RD_ISSUE, RD_WAIT, RD_HOLD.
- IDLE:
  - req_ready=1.
  - On req_valid: latch addr to addr_q and len to cnt_q.
  - Go to WR if req_write, else RD_ISSUE.
  - Only one command is outstanding at a time; req_ready=0 in every other state.
- WR:
  - wr_ready=1; ram_address=addr_q; ram_din=wr_data; ram_rw=wr_valid, combinational.
  - The RAM write occurs on the edge where wr_valid&wr_ready.
  - On each beat: addr_q+=1 mod 256 (255 wraps to 0); if cnt_q==0 go to IDLE, else cnt_q-=1.
  - wr_valid low: ram_rw=0, no write, stay in WR.
- RD_ISSUE:
  - ram_rw=0; ram_address=addr_q; lat_q loaded with RD_LAT-1.
  - Next state RD_WAIT.
- RD_WAIT:
  - ram_address held at addr_q; lat_q decrements.
  - When lat_q==0: capture ram_dout into rd_data, set rd_valid=1, go to RD_HOLD.
  - With RD_LAT=1, data is captured exactly one cycle after RD_ISSUE.
- RD_HOLD:
  - rd_valid=1; rd_data stable until rd_ready.
  - On rd_valid&rd_ready: rd_valid clears next cycle; addr_q+=1 mod 256.
  - Then: if cnt_q==0 go to IDLE, else cnt_q-=1 and go to RD_ISSUE.
  - Minimum read throughput is one beat per RD_LAT+2 cycles.
- ram_rw is 0 in every state except WR with wr_valid high, so no spurious writes.
- ram_address is registered from addr_q, except in WR, where it is still addr_q (no combinational path from request inputs).
- req_valid while busy: ignored, not lost; the requester must hold it until req_ready.
- wr_valid outside WR: ignored, wr_ready=0.
- rst mid-burst: immediate abort; remaining beats discarded; any write in flight on that edge does not occur (ram_rw forced 0 asynchronously); rd_valid drops.
- req_len=0: single beat, identical flow.
- Address wrap: a burst starting at 254 with len 3 accesses 254, 255, 0, 1.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=0, WR=1, RD_ISSUE=2, RD_WAIT=3, RD_HOLD=4, 3-bit);
  - RAM_RW_WRITE=1 and RAM_RW_READ=0;
  - ADDR_W/DATA_W defaults, shared with the RAM.
- Optional sub-module ram_ctrl_beat_cnt: address incrementer plus beat down-counter with a last-beat flag.
- Everything else stays in one module.

Test Plan:
- Reset then idle: rst pulse mid-cycle -> all outputs at reset values asynchronously; req_ready=1; ram_rw=0.
- Single write then read: write addr=0x10 data=0xDEADBEEF, then read addr=0x10 -> exactly one ram_rw=1 cycle at address 0x10; rd_data=0xDEADBEEF with rd_valid at RD_LAT+1 cycles after read acceptance.
- Wrapping burst:
  - Write burst addr=0xFE, len=3, data 0x1..0x4 -> writes at 0xFE, 0xFF, 0x00, 0x01.
  - Read burst from the same start -> rd_data sequence 1, 2, 3, 4.
- Stalls:
  - wr_valid low for 3 cycles mid-burst -> no writes during the gap, address unchanged.
  - rd_ready low for 5 cycles -> rd_data held constant, no new RAM read issued.
- Busy rejection: req_valid asserted during a read burst -> req_ready=0 until the last beat is consumed; command accepted in IDLE the next cycle.
- Reset mid-burst: rst during beat 2 of a 4-beat write -> beats 2-4 not written (RAM at those addresses keeps prior contents); state IDLE after release.
